// File: rtl/seg_reader_pkg.sv
// Shared definitions for the seven-segment display path: legal patterns,
// reader FSM states and the pattern-to-value decoder.
package seg_pkg;

   // Legal segment patterns (bit 7 is the minus segment)
   localparam logic [7:0] PAT_P0 = 8'h3F;
   localparam logic [7:0] PAT_P1 = 8'h06;
   localparam logic [7:0] PAT_P2 = 8'h5B;
   localparam logic [7:0] PAT_P3 = 8'h4F;
   localparam logic [7:0] PAT_N4 = 8'hE6;
   localparam logic [7:0] PAT_N3 = 8'hCF;
   localparam logic [7:0] PAT_N2 = 8'hDB;
   localparam logic [7:0] PAT_N1 = 8'h86;

   typedef enum logic {
      WAIT = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Returns {legal, value[2:0]}; value is two's complement, 0 when illegal.
   function automatic logic [3:0] seg_decode(input logic [7:0] pattern);
      logic [3:0] res;
      case (pattern)
         PAT_P0:  res = {1'b1, 3'b000};
         PAT_P1:  res = {1'b1, 3'b001};
         PAT_P2:  res = {1'b1, 3'b010};
         PAT_P3:  res = {1'b1, 3'b011};
         PAT_N4:  res = {1'b1, 3'b100};
         PAT_N3:  res = {1'b1, 3'b101};
         PAT_N2:  res = {1'b1, 3'b110};
         PAT_N1:  res = {1'b1, 3'b111};
         default: res = 4'b0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/seg_reader_if.sv
// Bus between the segment display under observation / the value consumer
// and the seg_reader block.
interface seg_reader_if #(
   parameter int NBITS_SEG = 8,
   parameter int NBITS_ERR = 8
);
   logic [NBITS_SEG-1:0] seg_in;
   logic                 ovf_in;
   logic                 out_ready;
   logic                 out_valid;
   logic [2:0]           value;
   logic                 ovf_out;
   logic                 err;
   logic [NBITS_ERR-1:0] err_count;

   // Environment side: drives the display lines and the consumer ready
   modport master (
      output seg_in, ovf_in, out_ready,
      input  out_valid, value, ovf_out, err, err_count
   );

   // Reader side
   modport slave (
      input  seg_in, ovf_in, out_ready,
      output out_valid, value, ovf_out, err, err_count
   );
endinterface

// File: rtl/seg_reader_stability.sv
// Input sampler and debounce counter. stable_o is high when the registered
// pattern has been seen on STABLE_CYCLES consecutive samples and the live
// input still matches it.
module seg_stability #(
   parameter int STABLE_CYCLES = 4,
   parameter int NBITS_SEG     = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NBITS_SEG-1:0] seg_i,
   input  logic                 ovf_i,
   output logic [NBITS_SEG-1:0] seg_o,
   output logic                 ovf_o,
   output logic                 stable_o
);
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);

   logic [NBITS_SEG-1:0] seg_q;
   logic                 ovf_q;
   logic [3:0]           stab_cnt_q;
   logic [3:0]           stab_cnt_d;
   logic                 same;

   assign same = (seg_i == seg_q);

   // Restart on any change, otherwise count up and park at CNT_MAX
   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if (!same)
         stab_cnt_d = '0;
      else if (stab_cnt_q != CNT_MAX)
         stab_cnt_d = stab_cnt_q + 4'd1;
   end

   // Sample the display lines every cycle and advance the counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q      <= '0;
         ovf_q      <= 1'b0;
         stab_cnt_q <= '0;
      end else begin
         seg_q      <= seg_i;
         ovf_q      <= ovf_i;
         stab_cnt_q <= stab_cnt_d;
      end
   end

   assign seg_o    = seg_q;
   assign ovf_o    = ovf_q;
   assign stable_o = same && (stab_cnt_q == CNT_MAX);
endmodule

// File: rtl/seg_reader.sv
// Seven-segment display reader: debounces the segment bus, reports each
// distinct stable legal pattern once as a signed 3-bit value over
// valid/ready, and counts illegal patterns.
module seg_reader
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int NBITS_SEG     = 8,
   parameter int NBITS_ERR     = 8
) (
   input  logic      clk_2,
   input  logic      reset_n,
   seg_reader_if.slave bus
);
   logic [NBITS_SEG-1:0] seg_q;
   logic                 ovf_q;
   logic                 stable;

   state_t               state_q;
   logic [NBITS_SEG-1:0] last_pat_q;
   logic                 last_pat_vld_q;
   logic                 out_valid_q;
   logic [2:0]           value_q;
   logic                 ovf_out_q;
   logic                 err_q;
   logic [NBITS_ERR-1:0] err_count_q;

   logic [3:0]           dec;
   logic                 new_pat;

   seg_stability #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .NBITS_SEG     (NBITS_SEG)
   ) u_stab (
      .clk_i    (clk_2),
      .rst_ni   (reset_n),
      .seg_i    (bus.seg_in),
      .ovf_i    (bus.ovf_in),
      .seg_o    (seg_q),
      .ovf_o    (ovf_q),
      .stable_o (stable)
   );

   assign dec     = seg_decode(seg_q);
   // A pattern that already produced a report is never reported twice in a row
   assign new_pat = stable && (!last_pat_vld_q || (seg_q != last_pat_q));

   // Reader FSM: accept new stable patterns in WAIT, hold the value in HOLD
   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= WAIT;
         last_pat_q     <= '0;
         last_pat_vld_q <= 1'b0;
         out_valid_q    <= 1'b0;
         value_q        <= '0;
         ovf_out_q      <= 1'b0;
         err_q          <= 1'b0;
         err_count_q    <= '0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            WAIT: begin
               if (new_pat) begin
                  last_pat_q     <= seg_q;
                  last_pat_vld_q <= 1'b1;
                  if (dec[3]) begin
                     value_q     <= dec[2:0];
                     ovf_out_q   <= ovf_q;
                     out_valid_q <= 1'b1;
                     state_q     <= HOLD;
                  end else begin
                     err_q <= 1'b1;
                     if (err_count_q != '1)
                        err_count_q <= err_count_q + NBITS_ERR'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            default: state_q <= WAIT;
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.value     = value_q;
   assign bus.ovf_out   = ovf_out_q;
   assign bus.err       = err_q;
   assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader: latency, hold/handshake, debounce,
// illegal-pattern counting with saturation, repeat suppression and
// asynchronous reset.
module tb_seg_reader;
   logic clk;
   logic reset_n;

   int checks   = 0;
   int failures = 0;

   // Transfer / error-pulse monitor
   int         xfer_cnt   = 0;
   int         err_pulses = 0;
   logic [2:0] last_val   = 3'b000;

   seg_reader_if #(.NBITS_SEG(8), .NBITS_ERR(8)) bus_if ();

   seg_reader #(
      .STABLE_CYCLES (4),
      .NBITS_SEG     (8),
      .NBITS_ERR     (8)
   ) dut (
      .clk_2   (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
         xfer_cnt = xfer_cnt + 1;
         last_val = bus_if.value;
      end
      if (bus_if.err === 1'b1)
         err_pulses = err_pulses + 1;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int x0;
      int e0;
      int n;

      reset_n          = 1'b0;
      bus_if.seg_in    = 8'h00;
      bus_if.ovf_in    = 1'b0;
      bus_if.out_ready = 1'b0;
      step(3);

      // Reset state
      chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_value", 32'(bus_if.value), 32'd0);
      chk("rst_ovf",   32'(bus_if.ovf_out), 32'd0);
      chk("rst_err",   32'(bus_if.err), 32'd0);
      chk("rst_errcnt", 32'(bus_if.err_count), 32'd0);

      // 1: 0x4F settles at release, reported 5 edges later, single pulse
      x0 = xfer_cnt;
      reset_n          = 1'b1;
      bus_if.seg_in    = 8'h4F;
      bus_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("t1_early_valid", 32'(bus_if.out_valid), 32'd0);
      end
      step(1);
      chk("t1_valid", 32'(bus_if.out_valid), 32'd1);
      chk("t1_value", 32'(bus_if.value), 32'd3);
      chk("t1_ovf",   32'(bus_if.ovf_out), 32'd0);
      step(1);
      chk("t1_drop",  32'(bus_if.out_valid), 32'd0);
      step(4);
      chk("t1_xfers", 32'(xfer_cnt - x0), 32'd1);

      // 2: 0xE6 with ovf, consumer stalled; pattern changes during HOLD
      x0 = xfer_cnt;
      bus_if.seg_in    = 8'hE6;
      bus_if.ovf_in    = 1'b1;
      bus_if.out_ready = 1'b0;
      step(8);
      chk("t2_valid", 32'(bus_if.out_valid), 32'd1);
      chk("t2_value", 32'(bus_if.value), 32'd4);
      chk("t2_ovf",   32'(bus_if.ovf_out), 32'd1);
      bus_if.seg_in = 8'h3F;
      bus_if.ovf_in = 1'b0;
      step(6);
      chk("t2_hold_valid", 32'(bus_if.out_valid), 32'd1);
      chk("t2_hold_value", 32'(bus_if.value), 32'd4);
      chk("t2_hold_ovf",   32'(bus_if.ovf_out), 32'd1);
      bus_if.out_ready = 1'b1;
      step(1);
      chk("t2_xfer_drop", 32'(bus_if.out_valid), 32'd0);
      chk("t2_xfer_val",  32'(last_val), 32'd4);
      step(1);
      chk("t2_next_valid", 32'(bus_if.out_valid), 32'd1);
      chk("t2_next_value", 32'(bus_if.value), 32'd0);
      chk("t2_next_ovf",   32'(bus_if.ovf_out), 32'd0);
      step(1);
      chk("t2_next_drop", 32'(bus_if.out_valid), 32'd0);
      chk("t2_xfers", 32'(xfer_cnt - x0), 32'd2);

      // 3: short 0x06 glitch then 0x5B stable
      x0 = xfer_cnt;
      bus_if.seg_in = 8'h06;
      step(2);
      bus_if.seg_in = 8'h5B;
      step(8);
      chk("t3_xfers", 32'(xfer_cnt - x0), 32'd1);
      chk("t3_value", 32'(last_val), 32'd2);

      // 4: illegal 0x00, then alternate 0xFF/0x00 until saturation
      x0 = xfer_cnt;
      e0 = err_pulses;
      bus_if.seg_in = 8'h00;
      step(4);
      chk("t4_err_early", 32'(bus_if.err), 32'd0);
      step(1);
      chk("t4_err_pulse", 32'(bus_if.err), 32'd1);
      chk("t4_errcnt1",   32'(bus_if.err_count), 32'd1);
      chk("t4_no_valid",  32'(bus_if.out_valid), 32'd0);
      step(1);
      chk("t4_err_drop",  32'(bus_if.err), 32'd0);
      step(2);
      chk("t4_pulses1",   32'(err_pulses - e0), 32'd1);
      for (int i = 0; i < 300; i++) begin
         bus_if.seg_in = (i % 2 == 0) ? 8'hFF : 8'h00;
         step(6);
         if (i == 252)
            chk("t4_errcnt254", 32'(bus_if.err_count), 32'd254);
      end
      chk("t4_errcnt_sat", 32'(bus_if.err_count), 32'd255);
      chk("t4_pulses",     32'(err_pulses - e0), 32'd301);
      chk("t4_xfers",      32'(xfer_cnt - x0), 32'd0);

      // 5: 0x86 held long, then 0x3F, then 0x86 again
      x0 = xfer_cnt;
      bus_if.seg_in = 8'h86;
      step(50);
      chk("t5_xfers_hold", 32'(xfer_cnt - x0), 32'd1);
      chk("t5_value",      32'(last_val), 32'd7);
      bus_if.seg_in = 8'h3F;
      step(8);
      chk("t5_value_3f",   32'(last_val), 32'd0);
      bus_if.seg_in = 8'h86;
      step(8);
      chk("t5_xfers", 32'(xfer_cnt - x0), 32'd3);
      chk("t5_value_86",   32'(last_val), 32'd7);

      // 6: async reset mid-HOLD, then 0x86 reported again
      bus_if.seg_in = 8'h3F;
      step(8);
      bus_if.out_ready = 1'b0;
      bus_if.seg_in    = 8'h86;
      step(8);
      chk("t6_hold_valid", 32'(bus_if.out_valid), 32'd1);
      chk("t6_hold_value", 32'(bus_if.value), 32'd7);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_valid",  32'(bus_if.out_valid), 32'd0);
      chk("t6_rst_value",  32'(bus_if.value), 32'd0);
      chk("t6_rst_errcnt", 32'(bus_if.err_count), 32'd0);
      chk("t6_rst_ovf",    32'(bus_if.ovf_out), 32'd0);
      step(1);
      reset_n          = 1'b1;
      bus_if.out_ready = 1'b1;
      n = 0;
      do begin
         step(1);
         n++;
      end while (bus_if.out_valid !== 1'b1 && n < 10);
      chk("t6_latency", 32'(n), 32'd5);
      chk("t6_value",   32'(bus_if.value), 32'd7);
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
